// File: rtl/multi_timer.sv
// multi_timer
//   Multi-channel loadable down-counter. Each channel can run as a one-shot
//   or as a periodic timer. Each channel can be paused or aborted on its own.
//   A single valid/ready load port programs any idle channel.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   load_valid     load request
//   load_ready     combinational; channel load_ch can accept a load
//   load_ch        target channel index (values >= NCH are never ready)
//   load_value     initial count V (V=0 gives an immediate done pulse)
//   load_periodic  0 = one-shot, 1 = periodic auto-reload
//   pause          per-channel freeze (level)
//   abort          per-channel cancel (level, highest priority)
//   cnt            live counts, channel i in bits [i*WIDTH +: WIDTH]
//   busy           channel i is counting
//   done           one-cycle expiry pulse per channel
module multi_timer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4,
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [CW-1:0]        load_ch,
    input  logic [WIDTH-1:0]     load_value,
    input  logic                 load_periodic,
    input  logic [NCH-1:0]       pause,
    input  logic [NCH-1:0]       abort,
    output logic [NCH*WIDTH-1:0] cnt,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state    [NCH];
    logic [WIDTH-1:0] cnt_r    [NCH];
    logic [WIDTH-1:0] reload_r [NCH];
    logic [NCH-1:0]   mode_r;
    logic [NCH-1:0]   busy_r;
    logic [NCH-1:0]   done_r;

    logic [NCH-1:0]   ch_sel;
    logic [NCH-1:0]   load_hit;
    logic             ready_c;

    // Channel decode by comparison rather than array indexing, so that
    // out-of-range indices (NCH not a power of two) simply match nothing.
    always_comb begin
        ch_sel  = '0;
        ready_c = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (load_ch == CW'(i)) begin
                ch_sel[i] = 1'b1;
                ready_c   = (state[i] == IDLE) && !abort[i];
            end
        end
        load_hit = {NCH{load_valid & ready_c}} & ch_sel;
    end

    assign load_ready = ready_c;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt[i*WIDTH +: WIDTH] = cnt_r[i];
        end
    end

    assign busy = busy_r;
    assign done = done_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state[i]    <= IDLE;
                cnt_r[i]    <= '0;
                reload_r[i] <= '0;
            end
            mode_r <= '0;
            busy_r <= '0;
            done_r <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                done_r[i] <= 1'b0;
                if (abort[i]) begin
                    // Abort wins even on the expiry edge: no done pulse.
                    state[i]  <= IDLE;
                    cnt_r[i]  <= '0;
                    busy_r[i] <= 1'b0;
                end else begin
                    case (state[i])
                        IDLE: begin
                            if (load_hit[i]) begin
                                if (load_value == '0) begin
                                    // Zero-length one-shot: expire at once.
                                    cnt_r[i]  <= '0;
                                    done_r[i] <= 1'b1;
                                end else begin
                                    cnt_r[i]    <= load_value;
                                    reload_r[i] <= load_value;
                                    mode_r[i]   <= load_periodic;
                                    state[i]    <= RUN;
                                    busy_r[i]   <= 1'b1;
                                end
                            end
                        end
                        RUN: begin
                            if (!pause[i]) begin
                                if (cnt_r[i] == WIDTH'(1)) begin
                                    done_r[i] <= 1'b1;
                                    if (mode_r[i]) begin
                                        cnt_r[i] <= reload_r[i];
                                    end else begin
                                        cnt_r[i]  <= '0;
                                        state[i]  <= IDLE;
                                        busy_r[i] <= 1'b0;
                                    end
                                end else begin
                                    cnt_r[i] <= cnt_r[i] - WIDTH'(1);
                                end
                            end
                        end
                        default: begin
                            state[i] <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
